fetch_stage: RTL

Instruction-fetch stage of the pipelined core, directly upstream of decode. It owns the fetch PC and drives a single-outstanding-request instruction-memory port. It absorbs variable memory latency and holds or discards fetched words under StallFetch, StallDecode, FlushDecode and PCSrcE from the hazard unit. It presents the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) to decode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/if_id_reg.sv | 79 +++++++
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (IDLE, WAIT, HOLD, DROP)
//   NOP_INSTR        : bubble instruction loaded into IF/ID (addi x0,x0,0)
//   RESET_PC_DEFAULT : default first fetch address after reset
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory port between the fetch stage and instruction memory.
// Single outstanding request; the response strobe arrives >=1 cycle later.
//   imem_req    : request pulse (fetch -> memory)
//   imem_addr   : request address, valid while imem_req=1
//   imem_rvalid : response strobe (memory -> fetch)
//   imem_rdata  : instruction word, valid with imem_rvalid
// Modports: master = fetch stage, slave = memory.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Update priority each cycle:
//   flush > stall > deliver > bubble
// A bubble loads NOP_INSTR with valid=0 and keeps the PC fields unchanged.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush, stall        : hazard controls
//   deliver             : a fetched word is presented this cycle
//   instr_in, pc_in     : the fetched word and its PC
//   instr_o, pc_o, pc_plus4_o, valid_o : register outputs
// ---------------------------------------------------------------------------
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  deliver,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (deliver) begin
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_in + ADDR_WIDTH'(4);
            valid_d    = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns PCF, issues at most one outstanding request
// on the instruction-memory port, buffers a word that arrives under
// StallFetch, discards responses from a squashed path, and drives IF/ID.
// Ports:
//   clk, rst_n                          : clock, synchronous active-low reset
//   StallFetch, StallDecode, FlushDecode: hazard-unit controls
//   PCSrcE, PCTargetE                   : redirect from execute
//   imem (fetch_stage_if.master)        : instruction-memory port
//   InstrD, PCD, PCPlus4D, ValidD       : IF/ID register outputs
// Optional (macro FETCH_PERF_CNT_EN):
//   wait_cycles    : cycles in WAIT without rvalid plus all DROP cycles
//   redirect_count : cycles with PCSrcE asserted
//   Both saturate at all-ones.
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallFetch,
    input  logic                  StallDecode,
    input  logic                  FlushDecode,
    input  logic                  PCSrcE,
    input  logic [ADDR_WIDTH-1:0] PCTargetE,
    fetch_stage_if.master         imem,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           wait_cycles,
    output logic [31:0]           redirect_count,
`endif
    output logic                  ValidD
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] pcf_plus4;

    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] deliver_instr;

    assign pcf_plus4 = pcf_q + ADDR_WIDTH'(4);

    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        hold_d        = hold_q;
        req           = 1'b0;
        req_addr      = pcf_q;
        deliver       = 1'b0;
        deliver_instr = hold_q;

        if (PCSrcE) begin
            // Redirect beats everything; the old path's word (if any) is lost.
            pcf_d  = PCTargetE;
            hold_d = '0;
            if ((state_q == WAIT || state_q == DROP) && !imem.imem_rvalid) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    req     = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (!StallFetch) begin
                            deliver       = 1'b1;
                            deliver_instr = imem.imem_rdata;
                            pcf_d         = pcf_plus4;
                            req           = 1'b1;
                            req_addr      = pcf_plus4;
                        end else begin
                            hold_d  = imem.imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!StallFetch) begin
                        deliver  = 1'b1;
                        pcf_d    = pcf_plus4;
                        req      = 1'b1;
                        req_addr = pcf_plus4;
                        state_d  = WAIT;
                    end
                end
                DROP: begin
                    // Squashed response: discard it and refetch from PCF.
                    if (imem.imem_rvalid) begin
                        req     = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // IDLE would otherwise request while reset is still held.
        if (!rst_n) begin
            req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pcf_q   <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            hold_q  <= hold_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = req ? req_addr : '0;

    // The delivered PC is always the pre-increment PCF.
    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (FlushDecode),
        .stall      (StallDecode),
        .deliver    (deliver),
        .instr_in   (deliver_instr),
        .pc_in      (pcf_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] wait_cycles_q, wait_cycles_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        wait_cycles_d    = wait_cycles_q;
        redirect_count_d = redirect_count_q;
        if (((state_q == WAIT && !imem.imem_rvalid) || state_q == DROP)
            && wait_cycles_q != 32'hFFFF_FFFF) begin
            wait_cycles_d = wait_cycles_q + 32'd1;
        end
        if (PCSrcE && redirect_count_q != 32'hFFFF_FFFF) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cycles_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            wait_cycles_q    <= wait_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign wait_cycles    = wait_cycles_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule
